// File: rtl/pipeline_sequencer_pkg.sv
// Shared types for the 5-stage pipeline sequencer: FSM encoding, stage control
// bundle, and the RUN-priority decode used both in RUN and on memory completion.
package pipeline_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } state_e;

    typedef struct packed {
        logic fetch;
        logic decode;
        logic execute;
        logic memory;
        logic writeback;
        logic flush;
        logic bubble;
        logic redirect;
    } ctrl_t;

    // Halt beats branch beats hazard; a squashed instruction's hazard is moot.
    function automatic ctrl_t run_ctrl(input logic halt, input logic branch,
                                       input logic hazard);
        ctrl_t c;
        c = '{fetch: 1'b1, decode: 1'b1, execute: 1'b1, memory: 1'b1,
              writeback: 1'b1, flush: 1'b0, bubble: 1'b0, redirect: 1'b0};
        if (halt) begin
            c.flush  = 1'b1;
            c.bubble = 1'b1;
        end else if (branch) begin
            c.redirect = 1'b1;
            c.flush    = 1'b1;
            c.bubble   = 1'b1;
        end else if (hazard) begin
            c.fetch  = 1'b0;
            c.decode = 1'b0;
            c.bubble = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Control bus between the CPU datapath (master) and the pipeline sequencer (slave).
// Inputs are level-sampled each cycle; outputs are combinational from state + inputs.
interface pipeline_sequencer_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 16
);
    logic                 i_hazard_stall;
    logic                 i_mem_req;
    logic                 i_mem_ready;
    logic                 i_branch_taken;
    logic                 i_halt;
    logic                 i_resume;
    logic                 o_fetch_en;
    logic                 o_decode_en;
    logic                 o_execute_en;
    logic                 o_memory_en;
    logic                 o_writeback_en;
    logic                 o_decode_flush;
    logic                 o_execute_bubble;
    logic                 o_pc_redirect;
    logic                 o_halted;
    logic                 o_fault;
    logic [CNT_WIDTH-1:0] o_stall_count;
    state_e               o_state;

    modport master (
        output i_hazard_stall, i_mem_req, i_mem_ready, i_branch_taken, i_halt, i_resume,
        input  o_fetch_en, o_decode_en, o_execute_en, o_memory_en, o_writeback_en,
               o_decode_flush, o_execute_bubble, o_pc_redirect, o_halted, o_fault,
               o_stall_count, o_state
    );

    modport slave (
        input  i_hazard_stall, i_mem_req, i_mem_ready, i_branch_taken, i_halt, i_resume,
        output o_fetch_en, o_decode_en, o_execute_en, o_memory_en, o_writeback_en,
               o_decode_flush, o_execute_bubble, o_pc_redirect, o_halted, o_fault,
               o_stall_count, o_state
    );

endinterface

// File: rtl/pipeline_sequencer_sat_counter.sv
// Saturating up-counter with async active-low reset; holds at all-ones, never wraps.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline control FSM: merges memory wait, halt, branch and hazard into stage
// enables and flush/bubble/redirect, with a memory-timeout watchdog and stall counter.
module pipeline_sequencer
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    pipeline_sequencer_if.slave  bus
);

    localparam int TO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    state_e            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              fault_q, fault_d;
    ctrl_t             ctrl;
    ctrl_t             ctrl_out;
    logic [CNT_WIDTH-1:0] stall_count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_RUN;
            to_cnt_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        fault_d  = fault_q;
        ctrl     = '0;
        case (state_q)
            ST_RUN: begin
                if (bus.i_mem_req && !bus.i_mem_ready) begin
                    state_d  = ST_MEM_WAIT;
                    to_cnt_d = TO_W'(1);
                end else begin
                    ctrl = run_ctrl(bus.i_halt, bus.i_branch_taken, bus.i_hazard_stall);
                    if (bus.i_halt) state_d = ST_HALTED;
                end
            end
            ST_MEM_WAIT: begin
                // Completion takes precedence over a timeout landing on the same cycle.
                if (bus.i_mem_ready) begin
                    ctrl     = run_ctrl(bus.i_halt, bus.i_branch_taken, bus.i_hazard_stall);
                    to_cnt_d = '0;
                    state_d  = bus.i_halt ? ST_HALTED : ST_RUN;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (to_cnt_q == TO_W'(MEM_TIMEOUT - 1)) begin
                        state_d = ST_HALTED;
                        fault_d = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                if (bus.i_resume && !fault_q) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Enables must read 0 for the whole time reset is held, not just after an edge.
    assign ctrl_out = i_reset_n ? ctrl : '0;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .inc   (!ctrl_out.fetch),
        .count (stall_count)
    );

    assign bus.o_fetch_en       = ctrl_out.fetch;
    assign bus.o_decode_en      = ctrl_out.decode;
    assign bus.o_execute_en     = ctrl_out.execute;
    assign bus.o_memory_en      = ctrl_out.memory;
    assign bus.o_writeback_en   = ctrl_out.writeback;
    assign bus.o_decode_flush   = ctrl_out.flush;
    assign bus.o_execute_bubble = ctrl_out.bubble;
    assign bus.o_pc_redirect    = ctrl_out.redirect;
    assign bus.o_halted         = (state_q == ST_HALTED);
    assign bus.o_fault          = fault_q;
    assign bus.o_stall_count    = stall_count;
    assign bus.o_state          = state_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed scoreboard bench for pipeline_sequencer with MEM_TIMEOUT=4, CNT_WIDTH=3.
module tb_pipeline_sequencer;
    import pipeline_ctrl_pkg::*;

    localparam int CW = 3;
    localparam int VW = 13;

    localparam logic [5:0] HAZ = 6'b100000;
    localparam logic [5:0] REQ = 6'b010000;
    localparam logic [5:0] RDY = 6'b001000;
    localparam logic [5:0] BR  = 6'b000100;
    localparam logic [5:0] HLT = 6'b000010;
    localparam logic [5:0] RES = 6'b000001;
    localparam logic [5:0] IDLE = 6'b000000;

    localparam logic [4:0] EN_ALL  = 5'b11111;
    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [4:0] EN_HAZ  = 5'b00111;

    localparam logic [2:0] P_NONE = 3'b000;
    localparam logic [2:0] FL = 3'b100;
    localparam logic [2:0] BU = 3'b010;
    localparam logic [2:0] RD = 3'b001;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [CW-1:0] exp_cnt;
    logic [VW-1:0] exp_q[$];
    string         tag_q[$];

    pipeline_sequencer_if #(.CNT_WIDTH(CW)) bus ();

    pipeline_sequencer #(.MEM_TIMEOUT(4), .CNT_WIDTH(CW)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] observe();
        return {bus.o_fetch_en, bus.o_decode_en, bus.o_execute_en, bus.o_memory_en,
                bus.o_writeback_en, bus.o_decode_flush, bus.o_execute_bubble,
                bus.o_pc_redirect, bus.o_halted, bus.o_fault, bus.o_stall_count};
    endfunction

    task automatic set_inputs(input logic [5:0] in);
        {bus.i_hazard_stall, bus.i_mem_req, bus.i_mem_ready,
         bus.i_branch_taken, bus.i_halt, bus.i_resume} = in;
    endtask

    // driver: one cycle of stimulus plus its expected outputs
    task automatic drive(input string tag, input logic [5:0] in, input logic [4:0] en,
                         input logic [2:0] pulses, input logic [1:0] hf);
        @(negedge clk);
        set_inputs(in);
        exp_q.push_back({en, pulses, hf, exp_cnt});
        tag_q.push_back(tag);
        if (!en[4] && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        set_inputs(IDLE);
        rst_n = 1'b0;
        #1;
        check_eq("rst_vec", 16'(observe()), 16'b0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            check_eq(tag_q.pop_front(), 16'(observe()), 16'(exp_q.pop_front()));
        end
    end

    initial begin
        total = 0;
        bad = 0;
        exp_cnt = '0;
        rst_n = 1'b0;
        set_inputs(IDLE);
        #12;
        check_eq("rst_hold", 16'(observe()), 16'b0);
        apply_reset();

        drive("haz0", HAZ, EN_HAZ, BU, 2'b00);
        drive("haz1", HAZ, EN_HAZ, BU, 2'b00);
        drive("haz_done", IDLE, EN_ALL, P_NONE, 2'b00);
        drive("br_haz", HAZ | BR, EN_ALL, FL | BU | RD, 2'b00);
        drive("br_after", IDLE, EN_ALL, P_NONE, 2'b00);
        drive("mw0", REQ, EN_NONE, P_NONE, 2'b00);
        drive("mw1", REQ, EN_NONE, P_NONE, 2'b00);
        drive("mw2", REQ, EN_NONE, P_NONE, 2'b00);
        drive("mw_rdy", REQ | RDY, EN_ALL, P_NONE, 2'b00);
        drive("mw_run", IDLE, EN_ALL, P_NONE, 2'b00);

        apply_reset();
        for (int i = 0; i < 4; i++) drive("to_stall", REQ, EN_NONE, P_NONE, 2'b00);
        drive("to_fault", RES, EN_NONE, P_NONE, 2'b11);
        for (int i = 0; i < 5; i++) drive("to_sat", RES, EN_NONE, P_NONE, 2'b11);

        apply_reset();
        drive("halt", HLT, EN_ALL, FL | BU, 2'b00);
        drive("halted", IDLE, EN_NONE, P_NONE, 2'b10);
        drive("resume", RES, EN_NONE, P_NONE, 2'b10);
        drive("resumed", IDLE, EN_ALL, P_NONE, 2'b00);
        drive("ms_halt_ign", REQ | HLT, EN_NONE, P_NONE, 2'b00);
        drive("mw_rdy_halt", REQ | RDY | HLT, EN_ALL, FL | BU, 2'b00);
        drive("halted2", IDLE, EN_NONE, P_NONE, 2'b10);

        apply_reset();
        for (int i = 0; i < 3; i++) drive("race_stall", REQ, EN_NONE, P_NONE, 2'b00);
        drive("race_rdy_br", REQ | RDY | BR, EN_ALL, FL | BU | RD, 2'b00);
        drive("race_run", IDLE, EN_ALL, P_NONE, 2'b00);
        drive("mw_a", REQ, EN_NONE, P_NONE, 2'b00);
        drive("mw_b", REQ, EN_NONE, P_NONE, 2'b00);

        // async reset while in MEM_WAIT with ready arriving
        @(negedge clk);
        set_inputs(REQ | RDY);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_en", 16'(observe()), 16'b0);
        @(negedge clk);
        set_inputs(IDLE);
        rst_n = 1'b1;
        exp_cnt = '0;
        #1;
        check_eq("post_state", 16'(bus.o_state), 16'(ST_RUN));
        drive("post_idle", IDLE, EN_ALL, P_NONE, 2'b00);

        repeat (2) @(negedge clk);
        #3;
        check_eq("drain", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
